// File: rtl/dht_pkg.sv
// Shared types and fixed DHT11 line timing for the humidity-link responder and reader.
// All durations are in 1 MHz clock cycles (1 cycle = 1 us).
package dht_pkg;

  localparam int FRAME_W = 40;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] RESP_LOW_US  = 16'd80;
  localparam logic [CNT_W-1:0] RESP_HIGH_US = 16'd80;
  localparam logic [CNT_W-1:0] BIT_LOW_US   = 16'd50;
  localparam logic [CNT_W-1:0] BIT0_HIGH_US = 16'd26;
  localparam logic [CNT_W-1:0] BIT1_HIGH_US = 16'd70;
  localparam logic [CNT_W-1:0] END_LOW_US   = 16'd50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_DELAY,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht_state_e;

  // Replace the last byte with the 8-bit wrapping sum of the first four.
  function automatic logic [FRAME_W-1:0] dht_fill_checksum(input logic [FRAME_W-1:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return {f[39:8], sum};
  endfunction

endpackage

// File: rtl/dht_line_sync.sv
// 2-FF synchronizer for the single-wire data line plus one-cycle rise/fall strobes.
// Strobes assert 2 cycles after the pad edge and are consumed on the following clock edge.
module dht_line_sync (
  input  logic clk1M,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  // Reset to the pulled-up idle level so reset release never fakes an edge.
  always_ff @(posedge clk1M) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

endmodule

// File: rtl/dht_responder.sv
// DHT11-style sensor responder: detects host start, answers 80/80 us, sends 40 PWM bits MSB first.
// DHT_CHECKSUM_EN: when defined, byte 0 is regenerated as the sum of the upper four bytes at frame load.
module dht_responder
  import dht_pkg::*;
#(
  parameter int MIN_START_US = 10000,
  parameter int RESP_WAIT_US = 30
) (
  input  logic               clk1M,
  input  logic               rst,
  input  logic               dq_in,
  output logic               dq_oe,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_we,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] MIN_START_C = CNT_W'(MIN_START_US);
  localparam logic [CNT_W-1:0] RESP_WAIT_C = CNT_W'(RESP_WAIT_US);

  dht_state_e         state;
  dht_state_e         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   dur;
  logic               seg_end;
  logic [IDX_W-1:0]   bit_idx;
  logic [FRAME_W-1:0] pending;
  logic [FRAME_W-1:0] shift;
  logic [FRAME_W-1:0] load_src;
  logic [FRAME_W-1:0] load_frame;
  logic               enter_resp;
  logic               line_rise;
  logic               line_fall;

  dht_line_sync u_sync (
    .clk1M (clk1M),
    .rst   (rst),
    .din   (dq_in),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  // Same-cycle frame_we bypasses the pending register so the newest frame is sent.
  assign load_src = frame_we ? frame_in : pending;
`ifdef DHT_CHECKSUM_EN
  assign load_frame = dht_fill_checksum(load_src);
`else
  assign load_frame = load_src;
`endif

  always_comb begin
    dur = '1;
    case (state)
      ST_RESP_DELAY: dur = RESP_WAIT_C;
      ST_RESP_LOW:   dur = RESP_LOW_US;
      ST_RESP_HIGH:  dur = RESP_HIGH_US;
      ST_BIT_LOW:    dur = BIT_LOW_US;
      ST_BIT_HIGH:   dur = shift[FRAME_W-1] ? BIT1_HIGH_US : BIT0_HIGH_US;
      ST_END_LOW:    dur = END_LOW_US;
      default:       dur = '1;
    endcase
  end

  assign seg_end = (cnt == dur - CNT_W'(1));

  always_ff @(posedge clk1M) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (line_fall) state_nxt = ST_HOST_LOW;
      ST_HOST_LOW:   if (line_rise) state_nxt = (cnt >= MIN_START_C) ? ST_RESP_DELAY : ST_IDLE;
      ST_RESP_DELAY: if (seg_end) state_nxt = ST_RESP_LOW;
      ST_RESP_LOW:   if (seg_end) state_nxt = ST_RESP_HIGH;
      ST_RESP_HIGH:  if (seg_end) state_nxt = ST_BIT_LOW;
      ST_BIT_LOW:    if (seg_end) state_nxt = ST_BIT_HIGH;
      ST_BIT_HIGH:   if (seg_end) state_nxt = (bit_idx == '0) ? ST_END_LOW : ST_BIT_LOW;
      ST_END_LOW:    if (seg_end) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dq_oe = 1'b0;
    busy  = 1'b0;
    case (state)
      ST_RESP_LOW, ST_BIT_LOW, ST_END_LOW: begin
        dq_oe = 1'b1;
        busy  = 1'b1;
      end
      ST_RESP_DELAY, ST_RESP_HIGH, ST_BIT_HIGH: busy = 1'b1;
      default: ;
    endcase
  end

  assign enter_resp = (state == ST_HOST_LOW) && (state_nxt == ST_RESP_DELAY);

  // One counter serves every state; it restarts on each transition and saturates while waiting.
  always_ff @(posedge clk1M) begin
    if (rst) begin
      cnt     <= '0;
      pending <= '0;
      shift   <= '0;
      bit_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_END_LOW) && (state_nxt == ST_IDLE);

      if (state_nxt != state)  cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CNT_W'(1);

      if (frame_we) pending <= frame_in;

      if (enter_resp)
        shift <= load_frame;
      else if (state == ST_BIT_HIGH && seg_end)
        shift <= {shift[FRAME_W-2:0], 1'b0};

      if (state == ST_RESP_HIGH && seg_end)
        bit_idx <= IDX_W'(FRAME_W - 1);
      else if (state == ST_BIT_HIGH && seg_end)
        bit_idx <= bit_idx - IDX_W'(1);
    end
  end

endmodule
